// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types.
//   lc3b_word / lc3b_four / lc3b_nzp  - 16/4/3-bit field types
//   lc3b_mem_state                    - memory-access stage FSM states
//   CS_*                              - bit positions inside the 4-bit cs word
//   cs_is_mem()                       - true when an instruction touches memory
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_four;
    typedef logic [2:0]  lc3b_nzp;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_ACCESS   = 2'd1,
        MS_INDIRECT = 2'd2,
        MS_COMPLETE = 2'd3
    } lc3b_mem_state;

    localparam int CS_MEM_READ  = 0;
    localparam int CS_MEM_WRITE = 1;
    localparam int CS_INDIRECT  = 2;
    localparam int CS_BYTE      = 3;

    // Indirect counts as a memory op even with no read/write bit: it always
    // fetches a pointer first.
    function automatic logic cs_is_mem(input lc3b_four cs);
        return cs[CS_MEM_READ] | cs[CS_MEM_WRITE] | cs[CS_INDIRECT];
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// mem_byte_align: combinational byte-lane handling for the data-memory port.
//   i_byte   - byte access (only meaningful on the final access)
//   i_addr0  - address bit 0, selects the high (1) or low (0) byte
//   i_write  - current access is a store
//   i_rdata  - raw memory read word      -> o_rdata: extracted/zero-extended result
//   i_wdata  - store data                -> o_wdata: byte replicated to both lanes
//   o_be     - byte enables: 11 word store, 10/01 byte store, 00 for reads
module mem_byte_align
    import lc3b_types::*;
(
    input  logic        i_byte,
    input  logic        i_addr0,
    input  logic        i_write,
    input  logic [15:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic [15:0] o_wdata,
    output logic [1:0]  o_be
);

    always_comb begin
        o_rdata = i_rdata;
        o_wdata = i_wdata;
        o_be    = i_write ? 2'b11 : 2'b00;
        if (i_byte) begin
            o_rdata = i_addr0 ? {8'h00, i_rdata[15:8]} : {8'h00, i_rdata[7:0]};
            // Replicate so the byte is on the right lane whichever one is enabled.
            o_wdata = {i_wdata[7:0], i_wdata[7:0]};
            if (i_write) o_be = i_addr0 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage feeding the MEM/WB register.
// Runs the data-memory handshake for loads, stores, byte accesses and LDI/STI,
// stalls upstream while memory is busy, and pulses wb_load with the results.
//   clk, reset_n (async, active-low)
//   stage_valid, ex_* (EX/MEM contents)       -> inputs from EX/MEM
//   stall                                     -> hold EX/MEM and upstream
//   mem_address/wdata/read/write/byte_enable  -> data-memory request
//   mem_rdata, mem_resp                       <- data-memory response
//   wb_load, wb_*                             -> MEM/WB load strobe and contents
//   mem_error                                 -> sticky timeout flag
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that get no
// mem_resp within TIMEOUT waiting cycles (sets mem_error, read result 0).
module mem_access_stage
    import lc3b_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stage_valid,
    input  logic [15:0] ex_address,
    input  logic [15:0] ex_data,
    input  logic [15:0] ex_npc,
    input  logic [15:0] ex_aluresult,
    input  logic [15:0] ex_ir,
    input  logic [3:0]  ex_cs,
    input  logic [2:0]  ex_drid,
    output logic        stall,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic        wb_load,
    output logic [15:0] wb_address,
    output logic [15:0] wb_data,
    output logic [15:0] wb_npc,
    output logic [15:0] wb_aluresult,
    output logic [15:0] wb_ir,
    output logic [3:0]  wb_cs,
    output logic [2:0]  wb_drid,
    output logic        mem_error
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT must be at least 1");
    end

    lc3b_mem_state r_state, w_next;

    lc3b_word r_address, r_data, r_npc, r_alu, r_ir, r_ptr, r_rdata;
    lc3b_four r_cs;
    lc3b_nzp  r_drid;

    logic     w_is_mem, w_accept, w_busy, w_final, w_write, w_timeout;
    lc3b_word w_addr, w_al_rdata, w_al_wdata;
    logic [1:0] w_al_be;

    assign w_is_mem = cs_is_mem(ex_cs);
    assign w_accept = (r_state == MS_IDLE) && stage_valid && w_is_mem;
    assign w_busy   = (r_state == MS_ACCESS) || (r_state == MS_INDIRECT);
    // The pointer fetch of an indirect is never the final access.
    assign w_final  = ((r_state == MS_ACCESS) && !r_cs[CS_INDIRECT]) ||
                      (r_state == MS_INDIRECT);
    assign w_write  = w_final && r_cs[CS_MEM_WRITE];
    assign w_addr   = (r_state == MS_INDIRECT) ? r_ptr : r_address;

    mem_byte_align u_align (
        .i_byte  (w_final && r_cs[CS_BYTE]),
        .i_addr0 (w_addr[0]),
        .i_write (w_write),
        .i_rdata (mem_rdata),
        .i_wdata (r_data),
        .o_rdata (w_al_rdata),
        .o_wdata (w_al_wdata),
        .o_be    (w_al_be)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] r_tcnt;
    logic          r_err;

    // Counter holds the number of waiting cycles already spent in this
    // access; the TIMEOUT-th unanswered cycle forces completion.
    assign w_timeout = w_busy && !mem_resp && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_tcnt <= '0;
            else if (w_busy && !mem_resp)
                r_tcnt <= r_tcnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign mem_error = r_err;
`else
    assign w_timeout = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            MS_IDLE:     if (w_accept) w_next = MS_ACCESS;
            MS_ACCESS: begin
                if (mem_resp)
                    w_next = r_cs[CS_INDIRECT] ? MS_INDIRECT : MS_COMPLETE;
                else if (w_timeout)
                    w_next = MS_COMPLETE;
            end
            MS_INDIRECT: if (mem_resp || w_timeout) w_next = MS_COMPLETE;
            MS_COMPLETE: w_next = MS_IDLE;
            default:     w_next = MS_IDLE;
        endcase
    end

    always_comb begin
        stall           = 1'b0;
        wb_load         = 1'b0;
        mem_read        = w_busy && !w_write;
        mem_write       = w_write;
        mem_address     = w_busy ? w_addr : 16'h0000;
        mem_wdata       = w_busy ? w_al_wdata : 16'h0000;
        mem_byte_enable = w_busy ? w_al_be : 2'b00;
        wb_address      = r_address;
        wb_data         = r_cs[CS_MEM_WRITE] ? r_data : r_rdata;
        wb_npc          = r_npc;
        wb_aluresult    = r_alu;
        wb_ir           = r_ir;
        wb_cs           = r_cs;
        wb_drid         = r_drid;
        case (r_state)
            MS_IDLE: begin
                // Non-memory instructions pass straight through in one cycle.
                stall        = stage_valid && w_is_mem;
                wb_load      = stage_valid && !w_is_mem;
                wb_address   = ex_address;
                wb_data      = ex_data;
                wb_npc       = ex_npc;
                wb_aluresult = ex_aluresult;
                wb_ir        = ex_ir;
                wb_cs        = ex_cs;
                wb_drid      = ex_drid;
            end
            MS_ACCESS, MS_INDIRECT: stall = 1'b1;
            MS_COMPLETE:            wb_load = 1'b1;
            default: ;
        endcase
        // Outputs are forced quiet for the whole reset, not just at the edge.
        if (!reset_n) begin
            stall           = 1'b0;
            wb_load         = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            mem_address     = 16'h0000;
            mem_wdata       = 16'h0000;
            mem_byte_enable = 2'b00;
            wb_address      = 16'h0000;
            wb_data         = 16'h0000;
            wb_npc          = 16'h0000;
            wb_aluresult    = 16'h0000;
            wb_ir           = 16'h0000;
            wb_cs           = 4'h0;
            wb_drid         = 3'h0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= MS_IDLE;
            r_address <= '0;
            r_data    <= '0;
            r_npc     <= '0;
            r_alu     <= '0;
            r_ir      <= '0;
            r_cs      <= '0;
            r_drid    <= '0;
            r_ptr     <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_address <= ex_address;
                r_data    <= ex_data;
                r_npc     <= ex_npc;
                r_alu     <= ex_aluresult;
                r_ir      <= ex_ir;
                r_cs      <= ex_cs;
                r_drid    <= ex_drid;
                r_rdata   <= '0;
            end
            if (mem_resp && (r_state == MS_ACCESS) && r_cs[CS_INDIRECT])
                r_ptr <= mem_rdata;
            if (mem_resp && w_final && !w_write)
                r_rdata <= w_al_rdata;
            else if (w_timeout)
                r_rdata <= '0;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting directly upstream of the MEM/WB stage register, between the EX/MEM register and that register's load/content inputs. It takes the latched instruction, runs the data-memory handshake for loads, stores, byte accesses and LDI/STI indirection, stalls the front of the pipe while memory is busy, and emits one `wb_load` pulse carrying the completed results.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_resp` before forcing completion (only with `MEM_TIMEOUT_EN`).
- `clk`  in  1  clock; one clock domain, all state on rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `stage_valid`  in  1  EX/MEM register holds a valid instruction.
- `ex_address`, `ex_data`, `ex_npc`, `ex_aluresult`, `ex_ir`  in  16 each  EX/MEM contents (`lc3b_word`).
- `ex_cs`  in  4  control: bit0 mem_read, bit1 mem_write, bit2 indirect, bit3 byte (`lc3b_four`).
- `ex_drid`  in  3  destination register id (`lc3b_nzp`).
- `stall`  out  1  hold EX/MEM and everything upstream.
- `mem_address`  out  16  data-memory address.
- `mem_wdata`  out  16  store data.
- `mem_read`, `mem_write`  out  1 each  request strobes, held until `mem_resp`.
- `mem_byte_enable`  out  2  write byte lanes.
- `mem_rdata`  in  16  read data, valid with `mem_resp`.
- `mem_resp`  in  1  single-cycle completion pulse.
- `wb_load`  out  1  load all MEM/WB register fields this cycle.
- `wb_address`, `wb_data`, `wb_npc`, `wb_aluresult`, `wb_ir`  out  16 each; `wb_cs` out 4; `wb_drid` out 3  MEM/WB contents.
- `mem_error`  out  1  sticky timeout flag.

## Operation
- States: IDLE, ACCESS, INDIRECT, COMPLETE.
- is_mem = cs[0] | cs[1] | cs[2].
- IDLE, `stage_valid`, !is_mem: `wb_load`=1 same cycle, wb_* = ex_* (wb_data = ex_data), `stall`=0, stay IDLE.
- IDLE, `stage_valid`, is_mem: latch all ex_* fields, `stall`=1, go ACCESS.
- ACCESS: address = latched address. Indirect: read (first phase always a read). Else cs[1] write, else read; cs[0] ignored when cs[1] set.
- `mem_resp` in ACCESS: indirect -> latch `mem_rdata` as pointer, go INDIRECT; else go COMPLETE (reads latch `mem_rdata`).
- INDIRECT: address = pointer; cs[1] selects STI write else LDI read; on `mem_resp` go COMPLETE.
- COMPLETE: `wb_load`=1, `stall`=0, wb_* from latched regs, wb_data = read result (loads) or latched data (stores); `stage_valid` ignored; next IDLE.
- Byte (cs[3], final access only): read result = zero-extended `mem_rdata[15:8]` if address[0] else `[7:0]`; store `mem_wdata` = {data[7:0], data[7:0]}, `mem_byte_enable` = address[0] ? 2'b10 : 2'b01. Word store enable 2'b11. Reads drive 2'b00.
- `mem_resp` outside ACCESS/INDIRECT ignored.

## Timing
- Reset: state IDLE, latched regs and pointer 0, `mem_error` 0, timeout counter 0; while `reset_n`=0 all outputs 0 (`stall`, `wb_load`, strobes forced low).
- Reset mid-operation: strobes drop immediately, transaction abandoned, no `wb_load`.
- Strobes combinational from state; first asserted the cycle after accept.
- `mem_resp` in cycle n -> next state takes effect n+1. Zero-wait single access: accept c0, strobe c1, `wb_load` c2. Zero-wait indirect: `wb_load` c3.
- `stall` high from accept cycle through last ACCESS/INDIRECT cycle; low in COMPLETE so upstream advances in the same edge MEM/WB loads.
- Strobe stays high ACCESS->INDIRECT; memory treats a new address after `mem_resp` as a new request.

## Configuration
- `MEM_TIMEOUT_EN` defined: counter clears on entering ACCESS/INDIRECT, increments each waiting cycle; reaching `TIMEOUT` without `mem_resp` sets `mem_error` (sticky until reset), goes COMPLETE with read result 16'h0000 (indirect aborts directly to COMPLETE).
- Undefined: no counter, waits indefinitely, `mem_error` tied 0.

## Structure
- Add to `lc3b_types`: state enum `lc3b_mem_state`, cs bit index constants (CS_MEM_READ, CS_MEM_WRITE, CS_INDIRECT, CS_BYTE).
- One sub-module `mem_byte_align`: combinational byte read extract and write lane/data replication.

## Test plan
- Non-mem ADD, stage_valid=1, aluresult 16'h1234 -> `wb_load`=1 same cycle, wb_aluresult 16'h1234, stall 0, no strobe.
- LDR address 16'h0040, resp 2 cycles after strobe with rdata 16'hBEEF -> stall 4 cycles, wb_data 16'hBEEF on the following `wb_load`.
- STB address 16'h0041, data 16'h00A5 -> mem_write, wdata 16'hA5A5, byte_enable 2'b10, single `wb_load`.
- LDI address 16'h0010, rdata 16'h0200 then 16'h7777 -> second read at 16'h0200, wb_data 16'h7777, `wb_load` in c3 with zero-wait memory.
- reset_n low mid-ACCESS -> strobes and stall drop immediately, no `wb_load`; next instruction processed normally.
- With `MEM_TIMEOUT_EN`, TIMEOUT=4, no resp -> COMPLETE after 4 waiting cycles, wb_data 16'h0000, `mem_error`=1 and stays 1.
